// File: rtl/taitosj_dpram_clr.sv
// Dual-port synchronous RAM with clock enable, selectable read-during-write behaviour,
// port-A-wins collision priority and a clear engine that fills the array after reset or on request.
module taitosj_dpram_clr #(
  parameter int             AW      = 11,
  parameter int             DW      = 8,
  parameter int             RDW_NEW = 0,
  parameter logic [DW-1:0]  CLR_VAL = '0
) (
  input  logic          clk,
  input  logic          nRESET,
  input  logic          cen,
  input  logic [AW-1:0] addr_a,
  input  logic [DW-1:0] data_a,
  input  logic          nWE_a,
  output logic [DW-1:0] q_a,
  input  logic [AW-1:0] addr_b,
  input  logic [DW-1:0] data_b,
  input  logic          nWE_b,
  output logic [DW-1:0] q_b,
  input  logic          clr_req,
  output logic          clr_busy
);

  localparam int DEPTH = 1 << AW;

  typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic [DW-1:0] q_a_q, q_a_d;
  logic [DW-1:0] q_b_q, q_b_d;

  logic [DW-1:0] mem [DEPTH];

  logic          idle;
  logic          req_a, req_b;
  logic          wr_a_en, wr_b_en;
  logic [AW-1:0] wr_a_addr;
  logic [DW-1:0] wr_a_data;

  assign idle  = (state_q == ST_IDLE);
  assign req_a = idle & cen & ~nWE_a;
  assign req_b = idle & cen & ~nWE_b;

  // The clear engine borrows port A's write path; port B is silenced on an address collision.
  assign wr_a_en   = ~idle | req_a;
  assign wr_a_addr = idle ? addr_a : cnt_q;
  assign wr_a_data = idle ? data_a : CLR_VAL;
  assign wr_b_en   = req_b & ~(req_a && (addr_a == addr_b));

  always_ff @(posedge clk) begin
    if (wr_b_en) mem[addr_b] <= data_b;
    if (wr_a_en) mem[wr_a_addr] <= wr_a_data;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    q_a_d   = q_a_q;
    q_b_d   = q_b_q;
    case (state_q)
      ST_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == {AW{1'b1}}) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        if (cen) begin
          q_a_d = ((RDW_NEW != 0) && req_a) ? data_a : mem[addr_a];
          q_b_d = ((RDW_NEW != 0) && req_b) ? data_b : mem[addr_b];
        end
        if (clr_req) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
      q_a_q   <= '0;
      q_b_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      q_a_q   <= q_a_d;
      q_b_q   <= q_b_d;
    end
  end

  assign q_a      = q_a_q;
  assign q_b      = q_b_q;
  assign clr_busy = busy_q;

endmodule

// File: tb/tb_taitosj_dpram_clr.sv
// Bench for taitosj_dpram_clr: two instances (old-data and new-data read-during-write) share one
// stimulus stream and are compared against a word-array model of the RAM and its clear sequence.
module tb_taitosj_dpram_clr;

  localparam int         AW    = 4;
  localparam int         DW    = 8;
  localparam int         DEPTH = 1 << AW;
  localparam logic [7:0] CLR   = 8'h5A;

  logic          clk = 1'b0;
  logic          nRESET;
  logic          cen;
  logic [AW-1:0] addr_a, addr_b;
  logic [DW-1:0] data_a, data_b;
  logic          nWE_a, nWE_b;
  logic          clr_req;
  logic [DW-1:0] q_a0, q_b0, q_a1, q_b1;
  logic          busy0, busy1;

  always #5 clk = ~clk;

  taitosj_dpram_clr #(.AW(AW), .DW(DW), .RDW_NEW(0), .CLR_VAL(CLR)) dut_old (
    .clk(clk), .nRESET(nRESET), .cen(cen),
    .addr_a(addr_a), .data_a(data_a), .nWE_a(nWE_a), .q_a(q_a0),
    .addr_b(addr_b), .data_b(data_b), .nWE_b(nWE_b), .q_b(q_b0),
    .clr_req(clr_req), .clr_busy(busy0));

  taitosj_dpram_clr #(.AW(AW), .DW(DW), .RDW_NEW(1), .CLR_VAL(CLR)) dut_new (
    .clk(clk), .nRESET(nRESET), .cen(cen),
    .addr_a(addr_a), .data_a(data_a), .nWE_a(nWE_a), .q_a(q_a1),
    .addr_b(addr_b), .data_b(data_b), .nWE_b(nWE_b), .q_b(q_b1),
    .clr_req(clr_req), .clr_busy(busy1));

  // Reference model: word array, expected q per instance, and number of clear cycles still owed.
  logic [7:0] m_mem [DEPTH];
  logic [7:0] e_qa [2];
  logic [7:0] e_qb [2];
  int         clear_left;
  int         compared   = 0;
  int         mismatched = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    clear_left = DEPTH;
    for (int r = 0; r < 2; r++) begin
      e_qa[r] = 8'h00;
      e_qb[r] = 8'h00;
    end
  endtask

  task automatic model_step();
    logic [7:0] old_a, old_b;
    if (clear_left > 0) begin
      m_mem[DEPTH - clear_left] = CLR;
      clear_left--;
    end else begin
      if (cen) begin
        old_a = m_mem[addr_a];
        old_b = m_mem[addr_b];
        e_qa[0] = old_a;
        e_qb[0] = old_b;
        e_qa[1] = !nWE_a ? data_a : old_a;
        e_qb[1] = !nWE_b ? data_b : old_b;
        if (!nWE_b) m_mem[addr_b] = data_b;
        if (!nWE_a) m_mem[addr_a] = data_a;
      end
      if (clr_req) clear_left = DEPTH;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, " busy0"}, 32'(busy0), 32'(clear_left > 0));
    check({tag, " busy1"}, 32'(busy1), 32'(clear_left > 0));
    check({tag, " qa0"}, 32'(q_a0), 32'(e_qa[0]));
    check({tag, " qb0"}, 32'(q_b0), 32'(e_qb[0]));
    check({tag, " qa1"}, 32'(q_a1), 32'(e_qa[1]));
    check({tag, " qb1"}, 32'(q_b1), 32'(e_qb[1]));
  endtask

  task automatic cyc(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  task automatic drive(input logic c, input logic [AW-1:0] aa, input logic [7:0] da, input logic wa,
                       input logic [AW-1:0] ab, input logic [7:0] db, input logic wb, input logic req);
    cen     = c;
    addr_a  = aa;
    data_a  = da;
    nWE_a   = !wa;
    addr_b  = ab;
    data_b  = db;
    nWE_b   = !wb;
    clr_req = req;
  endtask

  int         n;
  logic [7:0] hold_a0, hold_b0;

  initial begin
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'hxx;
    nRESET = 1'b0;
    drive(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all("reset");

    // Power-up clear must last exactly DEPTH cycles.
    @(negedge clk) nRESET = 1'b1;
    drive(1'b1, 4'd0, 8'h00, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0);
    n = 0;
    while (busy0 === 1'b1 && n < 40) begin
      cyc("clear");
      n++;
    end
    check("clear_len", 32'(n), 32'd16);

    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 4'(i), 8'h00, 1'b0, 4'(DEPTH - 1 - i), 8'h00, 1'b0, 1'b0);
      cyc("rd_clr");
      check("clr_val_a", 32'(q_a0), 32'h5A);
      check("clr_val_b", 32'(q_b1), 32'h5A);
    end

    // Top address write then read from both ports.
    drive(1'b1, 4'hF, 8'h3C, 1'b1, 4'd0, 8'h00, 1'b0, 1'b0);
    cyc("wr_top");
    drive(1'b1, 4'hF, 8'h00, 1'b0, 4'hF, 8'h00, 1'b0, 1'b0);
    cyc("rd_top");
    check("top_qa", 32'(q_a0), 32'h3C);
    check("top_qb", 32'(q_b0), 32'h3C);

    // Same-port read-during-write, with B watching the same word.
    drive(1'b1, 4'd5, 8'h11, 1'b1, 4'd5, 8'h00, 1'b0, 1'b0);
    cyc("rdw1");
    check("rdw1_old", 32'(q_a0), 32'h5A);
    check("rdw1_new", 32'(q_a1), 32'h11);
    check("rdw1_xport", 32'(q_b1), 32'h5A);
    drive(1'b1, 4'd5, 8'h22, 1'b1, 4'd5, 8'h00, 1'b0, 1'b0);
    cyc("rdw2");
    check("rdw2_old", 32'(q_a0), 32'h11);
    check("rdw2_new", 32'(q_a1), 32'h22);

    // Both ports write one address: A's data is kept.
    drive(1'b1, 4'd9, 8'hAA, 1'b1, 4'd9, 8'hBB, 1'b1, 1'b0);
    cyc("coll");
    check("coll_qb_new", 32'(q_b1), 32'hBB);
    check("coll_qb_old", 32'(q_b0), 32'h5A);
    drive(1'b1, 4'd9, 8'h00, 1'b0, 4'd9, 8'h00, 1'b0, 1'b0);
    cyc("coll_rd");
    check("coll_win_a", 32'(q_a0), 32'hAA);
    check("coll_win_b", 32'(q_b1), 32'hAA);

    // cen low: no write, outputs frozen.
    drive(1'b1, 4'd1, 8'h00, 1'b0, 4'd2, 8'h00, 1'b0, 1'b0);
    cyc("pre_cen");
    hold_a0 = e_qa[0];
    hold_b0 = e_qb[0];
    drive(1'b0, 4'd3, 8'hFF, 1'b1, 4'd3, 8'hFF, 1'b1, 1'b0);
    cyc("cen0_wr");
    drive(1'b0, 4'd7, 8'hFF, 1'b1, 4'd8, 8'h00, 1'b0, 1'b0);
    cyc("cen0_addr");
    check("cen0_hold_a", 32'(q_a0), 32'(hold_a0));
    check("cen0_hold_b", 32'(q_b0), 32'(hold_b0));
    drive(1'b1, 4'd3, 8'h00, 1'b0, 4'd3, 8'h00, 1'b0, 1'b0);
    cyc("cen0_rd");
    check("cen0_unchanged", 32'(q_a0), 32'h5A);

    // Requested clear, writes during it, then reset halfway through.
    drive(1'b1, 4'd0, 8'h00, 1'b0, 4'd0, 8'h00, 1'b0, 1'b1);
    cyc("clr_req");
    drive(1'b1, 4'd1, 8'h77, 1'b1, 4'd2, 8'h66, 1'b1, 1'b1);
    repeat (8) cyc("clr_mid");
    #2 nRESET = 1'b0;
    model_reset();
    #1;
    check_all("mid_reset");
    repeat (2) @(posedge clk);
    @(negedge clk) nRESET = 1'b1;
    drive(1'b1, 4'd4, 8'h44, 1'b1, 4'd6, 8'h66, 1'b1, 1'b0);
    n = 0;
    while (busy0 === 1'b1 && n < 40) begin
      cyc("reclear");
      n++;
    end
    check("reclear_len", 32'(n), 32'd16);
    drive(1'b1, 4'd4, 8'h00, 1'b0, 4'd6, 8'h00, 1'b0, 1'b0);
    cyc("lost_rd1");
    check("lost_a", 32'(q_a0), 32'h5A);
    check("lost_b", 32'(q_b0), 32'h5A);
    drive(1'b1, 4'd1, 8'h00, 1'b0, 4'd9, 8'h00, 1'b0, 1'b0);
    cyc("lost_rd2");
    check("lost_1", 32'(q_a0), 32'h5A);
    check("cleared_9", 32'(q_b0), 32'h5A);

    // Random traffic with narrow addresses to provoke collisions.
    for (int i = 0; i < 500; i++) begin
      drive(($urandom_range(0, 9) != 0),
            4'($urandom_range(0, (i % 2 == 0) ? 3 : 15)), 8'($urandom), ($urandom_range(0, 1) == 1),
            4'($urandom_range(0, (i % 2 == 0) ? 3 : 15)), 8'($urandom), ($urandom_range(0, 1) == 1),
            ($urandom_range(0, 99) == 0));
      cyc("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
